spi_rx_deser: RTL and testbench
===============================

// Module: spi_rx_deser
// PURPOSE
// - Parametrised SPI receive deserialiser, successor to the fixed 8-bit receiver.
// - Shifts i_bit in on each i_bit_stb while i_en is high (chip-select window). Bit order is selectable per word.
// - Completed words go into a DEPTH-entry FIFO with a valid/ready output, plus overrun and abort reporting.
// - Sits between the SPI bit-timing layer (which supplies strobes) and the L3 frame/command layer.
// PARAMETERS
// - DATA_W  default 8  word width in bits, >=2
// - DEPTH   default 4  output FIFO entries, power of two, >=2
// PORTS
// - clk            in   1                   clock
// - rst_n          in   1                   asynchronous, active-low reset
// - i_en           in   1                   frame window; low clears the partial word
// - i_bit_stb      in   1                   one-cycle sample strobe; ignored while i_en=0
// - i_bit          in   1                   serial data, valid when i_bit_stb=1
// - i_msb_first    in   1                   1=MSB first, 0=LSB first
// - o_data         out  DATA_W              FIFO head word
// - o_valid        out  1                   FIFO not empty
// - i_ready        in   1                   consumer accepts head when o_valid&i_ready
// - o_level        out  $clog2(DEPTH+1)     FIFO occupancy
// - o_abort        out  1                   one-cycle pulse: partial word discarded
// - o_overrun      out  1                   sticky: a completed word was dropped
// - i_clr_overrun  in   1                   synchronous clear of o_overrun
// BEHAVIOUR
// - Reset values: o_data=0, o_valid=0, o_level=0, o_abort=0, o_overrun=0; bit counter=0; shift reg=0.
// - Bit counter runs 0..DATA_W-1. Width is $clog2(DATA_W). It wraps to 0 after the last bit.
// - Word mode: i_msb_first is latched into a mode bit on the strobe that hits counter=0. It holds for the whole word.
// - MSB-first: shreg <= {shreg[DATA_W-2:0], i_bit}.
// - LSB-first: shreg <= {i_bit, shreg[DATA_W-1:1]}. After DATA_W bits, the first bit received sits in bit 0.
// - Completion: on the strobe with counter=DATA_W-1, the assembled word (shreg plus current bit) is pushed in that same edge.
// - Latency: o_valid=1 and o_data valid in the cycle after the last-bit edge, when the FIFO was empty.
// - FIFO pop: on o_valid&i_ready. o_data shows the new head in the next cycle.
// - Simultaneous push and pop: both happen and o_level is unchanged. This also holds when full, so the push is accepted.
// - Full with no pop: the completed word is dropped and o_overrun<=1. FIFO contents are untouched.
// - Overrun vs clear: if i_clr_overrun and a new drop occur in the same cycle, set wins.
// - i_en low: counter<=0 and shreg<=0 on each cycle.
//   - If counter!=0 on that edge, o_abort pulses high for exactly one cycle.
//   - A strobe in the same cycle is ignored.
// - i_en low has no effect on FIFO contents, o_valid or o_overrun.
// - Back-to-back words: the counter wraps without a gap. The mode is re-latched on the next word's first strobe.
// - Reset mid-word or mid-drain: all state returns to reset values immediately and stored words are lost.
// STRUCTURE
// - Shared package spi_pkg:
//   - bit-order encoding constants (SPI_MSB_FIRST=1, SPI_LSB_FIRST=0)
//   - DATA_W default
//   - width helper macro for counter and level widths
// - Sub-module spi_sync_fifo: #(W, DEPTH), push/pop/full/empty/level. It is reusable by the TX path.
// - Top level holds the counter, mode latch, shift register, abort and overrun logic.
// TESTING
// - MSB-first, DATA_W=8: bits 1,0,1,0,0,1,0,1 -> o_data=8'hA5, o_valid one cycle after the 8th strobe, o_level=1.
// - LSB-first, same bit stream -> o_data=8'hA5 reversed = 8'hA5 (palindrome check).
//   - Then send 1,0,0,0,0,0,0,0 -> 8'h01.
// - Abort: 3 strobes, then i_en=0 -> o_abort high for 1 cycle. The next full word decodes correctly with no residue.
// - Overrun, DEPTH=4, i_ready=0: send 5 words 8'h01..8'h05.
//   - o_level=4, o_overrun=1.
//   - Drain returns 01,02,03,04.
//   - i_clr_overrun -> o_overrun=0.
// - Full plus simultaneous pop: FIFO full, i_ready=1 on the last-bit edge -> word accepted, o_overrun stays 0, o_level stays 4.
// - Async reset asserted mid-word and with FIFO holding 2 words -> all outputs 0 immediately.
//   - The first word after release decodes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: bit-order encoding, default word width and a width helper.
package spi_pkg;

  // Bit-order encoding for i_msb_first and the latched word mode.
  localparam logic SPI_MSB_FIRST = 1'b1;
  localparam logic SPI_LSB_FIRST = 1'b0;

  // Default word width shared by the RX and TX paths.
  localparam int unsigned SPI_DATA_W_DEF = 8;

  // Bits needed to index n states; never less than one bit.
  function automatic int unsigned spi_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO with occupancy count. Push into a full FIFO succeeds only
// when a pop happens on the same edge; otherwise the push is rejected.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_wdata,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);

  localparam int unsigned AW = spi_width(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic w_pop;
  logic w_push;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_rx_deser.sv
// SPI receive deserialiser: assembles DATA_W-bit words from sampled bits,
// queues them in a small FIFO and reports aborted partial words and drops.
module spi_rx_deser
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_en,
  input  logic                         i_bit_stb,
  input  logic                         i_bit,
  input  logic                         i_msb_first,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_abort,
  output logic                         o_overrun,
  input  logic                         i_clr_overrun
);

  localparam int unsigned CNT_W = spi_width(DATA_W);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_mode;
  logic [DATA_W-1:0] r_shreg;
  logic              r_abort;
  logic              r_overrun;

  logic              w_stb;
  logic              w_first;
  logic              w_last;
  logic              w_mode;
  logic [DATA_W-1:0] w_shnext;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;

  assign w_stb   = i_en & i_bit_stb;
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));
  // The first bit of a word uses the live bit-order input; later bits use the latched mode.
  assign w_mode  = w_first ? i_msb_first : r_mode;

  // Shift-register next value for the current bit in the selected bit order.
  always_comb begin
    w_shnext = r_shreg;
    if (w_mode == SPI_MSB_FIRST) begin
      w_shnext = {r_shreg[DATA_W-2:0], i_bit};
    end else begin
      w_shnext = {i_bit, r_shreg[DATA_W-1:1]};
    end
  end

  assign w_push = w_stb & w_last;
  // A pop on the same edge frees a slot, so only a push into a full, non-draining FIFO drops.
  assign w_drop = w_push & w_full & ~(o_valid & i_ready);

  // Bit counter, word-mode latch, shift register and abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mode  <= SPI_LSB_FIRST;
      r_shreg <= '0;
      r_abort <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_shreg <= '0;
      r_abort <= ~w_first;
    end else begin
      r_abort <= 1'b0;
      if (w_stb) begin
        if (w_first) begin
          r_mode <= i_msb_first;
        end
        if (w_last) begin
          r_cnt   <= '0;
          r_shreg <= '0;
        end else begin
          r_cnt   <= r_cnt + CNT_W'(1);
          r_shreg <= w_shnext;
        end
      end
    end
  end

  // Sticky overrun flag; a new drop takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (i_clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  spi_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_shnext),
    .i_pop   (i_ready),
    .o_rdata (o_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  assign o_valid   = ~w_empty;
  assign o_abort   = r_abort;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser (DATA_W=8, DEPTH=4) with hand-computed expectations.
module tb_spi_rx_deser;

  logic       clk;
  logic       rst_n;
  logic       i_en;
  logic       i_bit_stb;
  logic       i_bit;
  logic       i_msb_first;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [2:0] o_level;
  logic       o_abort;
  logic       o_overrun;
  logic       i_clr_overrun;

  int n_chk;
  int n_err;

  spi_rx_deser #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .i_bit_stb     (i_bit_stb),
    .i_bit         (i_bit),
    .i_msb_first   (i_msb_first),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_level       (o_level),
    .o_abort       (o_abort),
    .o_overrun     (o_overrun),
    .i_clr_overrun (i_clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; the strobe is captured by the following posedge.
  task automatic send_bit(input logic b);
    i_bit_stb = 1'b1;
    i_bit     = b;
    @(negedge clk);
    i_bit_stb = 1'b0;
    i_bit     = 1'b0;
  endtask

  // Sends bits [first, last] of a word in the requested order.
  task automatic send_bits(input logic [7:0] w, input logic msb, input int first, input int last);
    i_msb_first = msb;
    for (int i = first; i <= last; i++) begin
      send_bit(msb ? w[7-i] : w[i]);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic msb);
    send_bits(w, msb, 0, 7);
  endtask

  task automatic pop_one();
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic expect_pop(input string tag, input logic [7:0] exp);
    check_eq(tag, {31'd0, o_valid}, 32'd1);
    check_eq(tag, {24'd0, o_data}, {24'd0, exp});
    pop_one();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    i_en = 1'b0;
    i_bit_stb = 1'b0;
    i_bit = 1'b0;
    i_msb_first = 1'b1;
    i_ready = 1'b0;
    i_clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst_data", {24'd0, o_data}, 32'd0);
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_level", {29'd0, o_level}, 32'd0);
    check_eq("rst_abort", {31'd0, o_abort}, 32'd0);
    check_eq("rst_overrun", {31'd0, o_overrun}, 32'd0);

    i_en = 1'b1;
    @(negedge clk);

    // MSB-first A5: nothing visible until the eighth strobe's edge.
    send_bits(8'hA5, 1'b1, 0, 6);
    check_eq("msb_pre_valid", {31'd0, o_valid}, 32'd0);
    send_bits(8'hA5, 1'b1, 7, 7);
    check_eq("msb_valid", {31'd0, o_valid}, 32'd1);
    check_eq("msb_data", {24'd0, o_data}, 32'hA5);
    check_eq("msb_level", {29'd0, o_level}, 32'd1);
    pop_one();
    check_eq("msb_popped_valid", {31'd0, o_valid}, 32'd0);
    check_eq("msb_popped_level", {29'd0, o_level}, 32'd0);

    // LSB-first, same stream 1,0,1,0,0,1,0,1 -> A5; then 1,0,...,0 -> 01.
    send_word(8'hA5, 1'b0);
    expect_pop("lsb_a5", 8'hA5);
    send_word(8'h01, 1'b0);
    expect_pop("lsb_01", 8'h01);

    // Mode latched on first bit: MSB-first 3C, order input flips after bit 0.
    send_bits(8'h3C, 1'b1, 0, 0);
    i_msb_first = 1'b0;
    for (int i = 1; i < 8; i++) begin
      send_bit(((8'h3C >> (7 - i)) & 8'h01) != 0);
    end
    expect_pop("mode_hold", 8'h3C);

    // Abort after 3 bits; a strobe while disabled is ignored.
    send_bits(8'hFF, 1'b1, 0, 2);
    i_en = 1'b0;
    @(negedge clk);
    check_eq("abort_pulse", {31'd0, o_abort}, 32'd1);
    i_bit_stb = 1'b1;
    i_bit = 1'b1;
    @(negedge clk);
    i_bit_stb = 1'b0;
    i_bit = 1'b0;
    check_eq("abort_single", {31'd0, o_abort}, 32'd0);
    check_eq("abort_no_push", {31'd0, o_valid}, 32'd0);
    i_en = 1'b1;
    send_word(8'h81, 1'b1);
    expect_pop("after_abort", 8'h81);

    // Overrun: four fill the FIFO; the fifth drops even with a clear on that edge.
    for (int k = 1; k <= 4; k++) begin
      send_word(8'(k), 1'b1);
    end
    check_eq("full_level", {29'd0, o_level}, 32'd4);
    check_eq("full_no_ovr", {31'd0, o_overrun}, 32'd0);
    send_bits(8'h05, 1'b1, 0, 6);
    i_clr_overrun = 1'b1;
    send_bits(8'h05, 1'b1, 7, 7);
    i_clr_overrun = 1'b0;
    check_eq("ovr_set", {31'd0, o_overrun}, 32'd1);
    check_eq("ovr_level", {29'd0, o_level}, 32'd4);
    i_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      expect_pop($sformatf("drain_%0d", k), 8'(k));
    end
    check_eq("drain_empty", {31'd0, o_valid}, 32'd0);
    check_eq("ovr_sticky", {31'd0, o_overrun}, 32'd1);
    i_clr_overrun = 1'b1;
    @(negedge clk);
    i_clr_overrun = 1'b0;
    check_eq("ovr_clr", {31'd0, o_overrun}, 32'd0);
    i_en = 1'b1;

    // Full plus simultaneous pop on the last-bit edge: word accepted.
    send_word(8'h10, 1'b1);
    send_word(8'h20, 1'b1);
    send_word(8'h30, 1'b1);
    send_word(8'h40, 1'b1);
    send_bits(8'h50, 1'b1, 0, 6);
    i_ready = 1'b1;
    send_bits(8'h50, 1'b1, 7, 7);
    i_ready = 1'b0;
    check_eq("fullpop_level", {29'd0, o_level}, 32'd4);
    check_eq("fullpop_ovr", {31'd0, o_overrun}, 32'd0);
    expect_pop("fullpop_20", 8'h20);
    expect_pop("fullpop_30", 8'h30);
    expect_pop("fullpop_40", 8'h40);
    expect_pop("fullpop_50", 8'h50);

    // Async reset mid-word with two stored words.
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b1);
    send_bits(8'hF0, 1'b1, 0, 2);
    check_eq("prerst_level", {29'd0, o_level}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_data", {24'd0, o_data}, 32'd0);
    check_eq("arst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("arst_level", {29'd0, o_level}, 32'd0);
    check_eq("arst_abort", {31'd0, o_abort}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(8'hC3, 1'b1);
    check_eq("postrst_level", {29'd0, o_level}, 32'd1);
    expect_pop("postrst_c3", 8'hC3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
